sram_axi_bridge: RTL and testbench

- Sits directly downstream of the CPU core's instruction and data memory ports.
- Converts the core's request/addr_ok/data_ok instruction and data ports into one AXI3 master with single-beat transfers.
- Arbitrates the shared read channel between the two ports.
- Runs a separate write FSM for data stores.

---
 rtl/sram_axi_bridge_pkg.sv | 30 +++
 rtl/sram_axi_bridge.sv | 183 ++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared encodings and constants for the core-port to AXI3 bridge.
// Both FSMs and the size mapping live here so the top stays readable.
package sram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2,
    R_DONE = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2,
    W_DONE = 2'd3
  } wr_state_t;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  // Instruction fetches are always full words.
  localparam logic [2:0] AXSIZE_WORD = 3'd2;

  // Core size code (0=byte, 1=half, 2=word) maps directly onto AXI AxSIZE.
  function automatic logic [2:0] core_size_to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the core's req/addr_ok/data_ok inst and data ports onto one AXI3
// master: a shared read FSM (data wins arbitration) and a separate store FSM.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic        bvalid,
  output logic        bready
);

  rd_state_t rstate;
  wr_state_t wstate;

  logic rd_is_data;   // current read belongs to the data port
  logic rd_data_ok;
  logic wr_data_ok;

  logic data_busy;
  logic rd_sel_data;
  logic rd_sel_inst;
  logic wr_accept;

  // A data read stays outstanding through R_DONE so a new data access
  // can only be accepted after its data_ok pulse.
  assign data_busy   = ((rstate != R_IDLE) && rd_is_data) || (wstate != W_IDLE);
  assign rd_sel_data = (rstate == R_IDLE) && data_req && !data_wr && !data_busy;
  assign rd_sel_inst = (rstate == R_IDLE) && inst_req && !rd_sel_data;
  assign wr_accept   = (wstate == W_IDLE) && data_req && data_wr && !data_busy && !rd_sel_data;

  assign inst_addr_ok = rd_sel_inst;
  assign data_addr_ok = rd_sel_data || wr_accept;
  assign data_data_ok = rd_data_ok || wr_data_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate       <= R_IDLE;
      rd_is_data   <= 1'b0;
      arid         <= 4'd0;
      araddr       <= 32'd0;
      arsize       <= 3'd0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      inst_data_ok <= 1'b0;
      rd_data_ok   <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
    end else begin
      inst_data_ok <= 1'b0;
      rd_data_ok   <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (rd_sel_data || rd_sel_inst) begin
            rstate     <= R_AR;
            arvalid    <= 1'b1;
            rd_is_data <= rd_sel_data;
            arid       <= rd_sel_data ? DATA_ID : INST_ID;
            araddr     <= rd_sel_data ? data_addr : inst_addr;
            arsize     <= rd_sel_data ? core_size_to_axsize(data_size) : AXSIZE_WORD;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            rstate  <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            rready <= 1'b0;
            rstate <= R_DONE;
            // Completion is steered by the returned id, not the request record.
            if (rid == DATA_ID) begin
              data_rdata <= rdata;
              rd_data_ok <= 1'b1;
            end else begin
              inst_rdata   <= rdata;
              inst_data_ok <= 1'b1;
            end
          end
        end
        R_DONE: begin
          rstate     <= R_IDLE;
          rd_is_data <= 1'b0;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate     <= W_IDLE;
      awid       <= 4'd0;
      awaddr     <= 32'd0;
      awsize     <= 3'd0;
      awvalid    <= 1'b0;
      wdata      <= 32'd0;
      wstrb      <= 4'd0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      wr_data_ok <= 1'b0;
    end else begin
      wr_data_ok <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (wr_accept) begin
            wstate  <= W_REQ;
            awid    <= DATA_ID;
            awaddr  <= data_addr;
            awsize  <= core_size_to_axsize(data_size);
            wdata   <= data_wdata;
            wstrb   <= data_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
          end
        end
        W_REQ: begin
          // AW and W complete independently, in either order.
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            wstate <= W_B;
            bready <= 1'b1;
          end
        end
        W_B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            wr_data_ok <= 1'b1;
            wstate     <= W_DONE;
          end
        end
        W_DONE: wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: an AXI slave model with per-channel
// ready delays, and a scoreboard that checks every data_ok against queued expectations.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  // ---------------- AXI slave model ----------------
  int ar_delay = 0, aw_delay = 0, w_delay = 0;
  int ar_wait, aw_wait, w_wait;
  logic [31:0] mem [256];
  logic        aw_got, w_got;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;

  assign arready = (ar_wait >= ar_delay);
  assign awready = (aw_wait >= aw_delay);
  assign wready  = (w_wait >= w_delay);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_wait <= 0; aw_wait <= 0; w_wait <= 0;
      rvalid <= 1'b0; rid <= 4'd0; rdata <= 32'd0;
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0;
      s_awaddr <= 32'd0; s_wdata <= 32'd0; s_wstrb <= 4'd0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[8'h00] <= 32'h02800C0C;   // 0x1C000000
      mem[8'h01] <= 32'h03400000;   // 0x1C000004
      mem[8'h40] <= 32'h11112222;   // 0x100..0x103
    end else begin
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_wait <= 0;
        rvalid  <= 1'b1;
        rid     <= arid;
        rdata   <= mem[araddr[9:2]];
      end else if (arvalid) ar_wait <= ar_wait + 1;
      if (awvalid && awready) begin
        aw_wait <= 0; aw_got <= 1'b1; s_awaddr <= awaddr;
      end else if (awvalid) aw_wait <= aw_wait + 1;
      if (wvalid && wready) begin
        w_wait <= 0; w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb;
      end else if (wvalid) w_wait <= w_wait + 1;
      if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1;
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
  } dexp_t;

  logic [31:0] exp_inst[$];
  dexp_t       exp_data[$];
  int          n_inst_ok = 0;
  int          n_data_ok = 0;
  logic [31:0] last_drd = 32'd0;   // data_rdata must hold this across store completions

  initial begin
    logic [31:0] ei;
    dexp_t ed;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (inst_data_ok) begin
          n_inst_ok++;
          if (exp_inst.size() == 0) fail("inst_data_ok with nothing outstanding");
          else begin
            ei = exp_inst.pop_front();
            chk("inst_rdata", inst_rdata, ei);
          end
        end
        if (data_data_ok) begin
          n_data_ok++;
          if (exp_data.size() == 0) fail("data_data_ok with nothing outstanding");
          else begin
            ed = exp_data.pop_front();
            if (ed.is_wr) chk("store_rdata_hold", data_rdata, last_drd);
            else begin
              chk("data_rdata", data_rdata, ed.data);
              last_drd = ed.data;
            end
          end
        end
      end
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_inst.size() != 0 || exp_data.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk({tag, "_drain"}, exp_inst.size() + exp_data.size(), 32'd0);
  endtask

  function automatic logic any_out();
    return |{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
             arid, araddr, arsize, arvalid, rready, awid, awaddr, awsize, awvalid,
             wdata, wstrb, wvalid, bready};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, n;
    reset = 1'b1;
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outs_zero", {31'd0, any_out()}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // T1: minimum-latency inst fetch
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C000000; #1;
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    exp_inst.push_back(32'h02800C0C);
    @(negedge clk); inst_req = 0; #1;
    chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("t1_arid", {28'd0, arid}, 32'd0);
    chk("t1_araddr", araddr, 32'h1C000000);
    chk("t1_arsize", {29'd0, arsize}, 32'd2);
    @(negedge clk); #1;
    chk("t1_r_handshake", {31'd0, rvalid & rready}, 32'd1);
    @(negedge clk); #1;
    chk("t1_inst_data_ok_cycle3", {31'd0, inst_data_ok}, 32'd1);
    drain("t1");

    // T2: data read wins over simultaneous inst fetch
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C000004;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h100; #1;
    chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    exp_data.push_back(dexp_t'{1'b0, 32'h11112222});
    base = n_data_ok;
    @(negedge clk); data_req = 0; #1;
    chk("t2_araddr", araddr, 32'h100);
    chk("t2_arid", {28'd0, arid}, 32'd1);
    n = 0;
    while (!inst_addr_ok && n < 40) begin @(negedge clk); #1; n++; end
    if (!inst_addr_ok) fail("t2_inst_accept timeout");
    else begin
      chk("t2_inst_after_data_done", n_data_ok - base, 32'd1);
      exp_inst.push_back(32'h03400000);
    end
    @(negedge clk); inst_req = 0;
    drain("t2");

    // T3: store with AW delayed, W immediate
    aw_delay = 3; w_delay = 0;
    @(negedge clk);
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h200;
    data_wdata = 32'h000055AA; data_wstrb = 4'hF; #1;
    chk("t3_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    exp_data.push_back(dexp_t'{1'b1, 32'h0});
    base = n_data_ok;
    @(negedge clk); data_req = 0; #1;
    chk("t3_aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
    chk("t3_awaddr", awaddr, 32'h200);
    chk("t3_awid", {28'd0, awid}, 32'd1);
    chk("t3_awsize", {29'd0, awsize}, 32'd2);
    chk("t3_wdata", wdata, 32'h000055AA);
    chk("t3_wstrb", {28'd0, wstrb}, 32'hF);
    @(negedge clk); #1;
    chk("t3_w_first", {30'd0, awvalid, wvalid}, 32'd2);
    @(negedge clk); #1;
    chk("t3_aw_held", {30'd0, awvalid, wvalid}, 32'd2);
    drain("t3");
    repeat (3) @(negedge clk);
    chk("t3_single_data_ok", n_data_ok - base, 32'd1);
    aw_delay = 1; w_delay = 2;

    // T4: load behind a store to the same address waits for the B response
    @(negedge clk);
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h300;
    data_wdata = 32'hCAFEF00D; data_wstrb = 4'hF; #1;
    chk("t4_store_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    exp_data.push_back(dexp_t'{1'b1, 32'h0});
    base = n_data_ok;
    @(negedge clk); data_wr = 0; #1;
    n = 0;
    while (!data_addr_ok && n < 40) begin @(negedge clk); #1; n++; end
    if (!data_addr_ok) fail("t4_load_accept timeout");
    else begin
      chk("t4_load_after_store_ok", n_data_ok - base, 32'd1);
      chk("t4_load_was_withheld", {31'd0, n >= 4}, 32'd1);
      exp_data.push_back(dexp_t'{1'b0, 32'hCAFEF00D});
    end
    @(negedge clk); data_req = 0;
    drain("t4");

    // T5: byte load keeps the unaligned address and size 0
    aw_delay = 0; w_delay = 0;
    @(negedge clk);
    data_req = 1; data_wr = 0; data_size = 2'd0; data_addr = 32'h103; #1;
    chk("t5_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    exp_data.push_back(dexp_t'{1'b0, 32'h11112222});
    @(negedge clk); data_req = 0; #1;
    chk("t5_arsize", {29'd0, arsize}, 32'd0);
    chk("t5_araddr", araddr, 32'h103);
    drain("t5");

    // T6: reset in the middle of a read, then a clean fetch
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C000000; #1;
    chk("t6_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk); inst_req = 0;
    @(negedge clk); #1;
    chk("t6_in_r_state", {31'd0, rready}, 32'd1);
    reset = 1'b1; #1;
    chk("t6_reset_outs_zero", {31'd0, any_out()}, 32'd0);
    last_drd = 32'd0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); inst_req = 1; inst_addr = 32'h1C000000; #1;
    chk("t6_refetch_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    exp_inst.push_back(32'h02800C0C);
    @(negedge clk); inst_req = 0;
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
